// File: rtl/spi_shift_sequencer_pkg.sv
// Shared definitions for the SPI shift sequencer: shift-register mode codes and
// sequencer state encodings.
package spi_shift_sequencer_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_RIGHT = 2'b01,
    MODE_LEFT  = 2'b10,
    MODE_PLOAD = 2'b11
  } shreg_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/spi_shift_sequencer_tx.sv
// One-entry transmit holding register with a valid/ready write side and a
// consume port; the data register reads as FILL whenever the entry is empty.
module spi_shift_sequencer_tx
  import spi_shift_sequencer_pkg::*;
#(
  parameter int unsigned       WIDTH = 8,
  parameter logic [WIDTH-1:0]  FILL  = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_consume,
  output logic             o_full,
  output logic [WIDTH-1:0] o_data
);

  logic             r_full;
  logic [WIDTH-1:0] r_data;
  logic             w_capture;

  assign w_capture = i_valid & ~r_full;

  // A capture can only happen while empty, so capture after consume keeps it full.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_full <= 1'b0;
      r_data <= FILL;
    end else if (w_capture) begin
      r_full <= 1'b1;
      r_data <= i_data;
    end else if (i_consume) begin
      r_full <= 1'b0;
      r_data <= FILL;
    end
  end

  assign o_ready = ~r_full;
  assign o_full  = r_full;
  assign o_data  = r_data;

endmodule

// File: rtl/spi_shift_sequencer.sv
// Sequences an external 8-bit shift register as the SPI serial engine: per
// chip-select byte it parallel-loads the transmit byte, shifts MSB-first and
// hands the received byte on, with abort handling and sticky error flags.
module spi_shift_sequencer
  import spi_shift_sequencer_pkg::*;
#(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] FILL  = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cs_n,
  input  logic                   sclk_posedge,
  input  logic [WIDTH-1:0]       tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  input  logic [WIDTH-1:0]       shreg_parallel_out,
  output logic [1:0]             shreg_mode,
  output logic                   shreg_edge,
  output logic [WIDTH-1:0]       shreg_parallel_in,
  output logic [WIDTH-1:0]       rx_data,
  output logic                   rx_valid,
  output logic                   busy,
  output logic [$clog2(WIDTH):0] bit_count,
  output logic                   abort,
  output logic                   err_overrun,
  output logic                   err_underrun,
  input  logic                   err_clr
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  seq_state_e       r_state;
  logic             r_busy;
  logic [CNT_W-1:0] r_bit_count;
  logic [WIDTH-1:0] r_rx_data;
  logic             r_rx_valid;
  logic             r_abort;
  logic             r_err_overrun;
  logic             r_err_underrun;

  logic             w_buf_full;
  logic             w_consume;
  logic             w_last_shift;
  logic             w_late_edge;
  shreg_mode_e      w_mode;
  logic             w_edge;

  assign w_consume    = (r_state == ST_LOAD);
  assign w_last_shift = sclk_posedge && (r_bit_count == CNT_W'(WIDTH - 1));
  assign w_late_edge  = sclk_posedge && ((r_state == ST_LOAD) || (r_state == ST_DONE));

  spi_shift_sequencer_tx #(
    .WIDTH (WIDTH),
    .FILL  (FILL)
  ) u_tx_buf (
    .i_clk     (clk),
    .i_rst     (reset),
    .i_data    (tx_data),
    .i_valid   (tx_valid),
    .o_ready   (tx_ready),
    .i_consume (w_consume),
    .o_full    (w_buf_full),
    .o_data    (shreg_parallel_in)
  );

  // Shift-register control follows the state directly so a sampling edge shifts in its own cycle.
  always_comb begin
    w_mode = MODE_HOLD;
    w_edge = 1'b0;
    case (r_state)
      ST_LOAD: begin
        w_mode = MODE_PLOAD;
        w_edge = 1'b1;
      end
      ST_SHIFT: begin
        if (sclk_posedge) begin
          w_mode = MODE_LEFT;
          w_edge = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign shreg_mode = w_mode;
  assign shreg_edge = w_edge;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_busy         <= 1'b0;
      r_bit_count    <= '0;
      r_rx_data      <= '0;
      r_rx_valid     <= 1'b0;
      r_abort        <= 1'b0;
      r_err_overrun  <= 1'b0;
      r_err_underrun <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_abort    <= 1'b0;

      // Clear first so a same-cycle set event below takes priority.
      if (err_clr) begin
        r_err_overrun  <= 1'b0;
        r_err_underrun <= 1'b0;
      end
      if (w_late_edge) begin
        r_err_overrun <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (!cs_n) begin
            r_state <= ST_LOAD;
            r_busy  <= 1'b1;
          end
        end

        ST_LOAD: begin
          r_bit_count <= '0;
          if (!w_buf_full) begin
            r_err_underrun <= 1'b1;
          end
          if (cs_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_abort <= 1'b1;
          end else begin
            r_state <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          if (sclk_posedge) begin
            r_bit_count <= r_bit_count + CNT_W'(1);
          end
          // Final edge wins over a simultaneous chip-select release.
          if (w_last_shift) begin
            r_state <= ST_DONE;
          end else if (cs_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_abort <= 1'b1;
          end
        end

        ST_DONE: begin
          r_rx_data  <= shreg_parallel_out;
          r_rx_valid <= 1'b1;
          if (cs_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= ST_LOAD;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy         = r_busy;
  assign bit_count    = r_bit_count;
  assign rx_data      = r_rx_data;
  assign rx_valid     = r_rx_valid;
  assign abort        = r_abort;
  assign err_overrun  = r_err_overrun;
  assign err_underrun = r_err_underrun;

endmodule

// File: tb/tb_spi_shift_sequencer.sv
// Scoreboard bench for spi_shift_sequencer: a behavioural shift register closes
// the loop, and monitors check every PLOAD and received byte against queues.
module tb_spi_shift_sequencer;
  import spi_shift_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cs_n = 1'b1;
  logic       sclk_posedge = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] shreg_parallel_out;
  logic [1:0] shreg_mode;
  logic       shreg_edge;
  logic [7:0] shreg_parallel_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic [3:0] bit_count;
  logic       abort;
  logic       err_overrun;
  logic       err_underrun;
  logic       err_clr = 1'b0;

  logic       mosi = 1'b0;
  logic [7:0] sh_q = '0;

  int n_tests = 0;
  int n_fail  = 0;
  int left_cnt = 0;
  int abort_cnt = 0;
  logic watch_busy = 1'b0;
  logic busy_dropped = 1'b0;

  logic [7:0] pload_q[$];
  logic [7:0] rx_q[$];

  spi_shift_sequencer #(.WIDTH(8), .FILL(8'h00)) dut (
    .clk                (clk),
    .reset              (reset),
    .cs_n               (cs_n),
    .sclk_posedge       (sclk_posedge),
    .tx_data            (tx_data),
    .tx_valid           (tx_valid),
    .tx_ready           (tx_ready),
    .shreg_parallel_out (shreg_parallel_out),
    .shreg_mode         (shreg_mode),
    .shreg_edge         (shreg_edge),
    .shreg_parallel_in  (shreg_parallel_in),
    .rx_data            (rx_data),
    .rx_valid           (rx_valid),
    .busy               (busy),
    .bit_count          (bit_count),
    .abort              (abort),
    .err_overrun        (err_overrun),
    .err_underrun       (err_underrun),
    .err_clr            (err_clr)
  );

  always #5 clk = ~clk;

  // Behavioural shiftregister8: MSB-first, serial input from mosi.
  always @(posedge clk) begin
    if (shreg_edge) begin
      case (shreg_mode)
        MODE_PLOAD: sh_q <= shreg_parallel_in;
        MODE_LEFT:  sh_q <= {sh_q[6:0], mosi};
        default:    sh_q <= sh_q;
      endcase
    end
  end
  assign shreg_parallel_out = sh_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expected PLOAD bytes and received bytes as the DUT presents them.
  always @(negedge clk) begin
    if (!reset) begin
      if (shreg_edge && shreg_mode == MODE_PLOAD) begin
        if (pload_q.size() == 0) chk("unexpected_pload", 32'(shreg_parallel_in), 32'hFFFF_FFFF);
        else chk("pload_data", 32'(shreg_parallel_in), 32'(pload_q.pop_front()));
      end
      if (rx_valid) begin
        if (rx_q.size() == 0) chk("unexpected_rx_valid", 32'(rx_data), 32'hFFFF_FFFF);
        else chk("rx_data", 32'(rx_data), 32'(rx_q.pop_front()));
      end
      if (shreg_edge && shreg_mode == MODE_LEFT) left_cnt++;
      if (abort) abort_cnt++;
      if (watch_busy && !busy) busy_dropped = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_tx(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
  endtask

  // n MSB-first SCLK pulses from b, one clk wide, 4 clk apart; returns in the cycle after the last.
  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      mosi = b[7-i];
      sclk_posedge = 1'b1;
      tick();
      sclk_posedge = 1'b0;
      if (i != n - 1) repeat (3) tick();
    end
  endtask

  // Chip select low, then one LOAD cycle and entry into SHIFT.
  task automatic start_frame();
    cs_n = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_abort", 32'(abort), 32'd0);
    chk("rst_bit_count", 32'(bit_count), 32'd0);
    chk("rst_flags", 32'({err_overrun, err_underrun}), 32'd0);
    chk("rst_mode", 32'({shreg_mode, shreg_edge}), 32'd0);
    reset = 1'b0;
    tick();

    // Single frame: TX A5, receive 3C
    put_tx(8'hA5);
    chk("tx_ready_full", 32'(tx_ready), 32'd0);
    pload_q.push_back(8'hA5);
    rx_q.push_back(8'h3C);
    left_cnt = 0;
    cs_n = 1'b0;
    tick();
    chk("pload_1clk_after_cs", 32'(shreg_mode), 32'(MODE_PLOAD));
    chk("pload_edge", 32'(shreg_edge), 32'd1);
    tick();
    chk("tx_ready_after_load", 32'(tx_ready), 32'd1);
    send_bits(8'h3C, 8);
    cs_n = 1'b1;
    chk("single_bit_count", 32'(bit_count), 32'd8);
    chk("single_no_rx_yet", 32'(rx_valid), 32'd0);
    tick();
    chk("single_rx_valid", 32'(rx_valid), 32'd1);
    chk("single_rx_data", 32'(rx_data), 32'h3C);
    chk("single_idle", 32'(busy), 32'd0);
    chk("single_left_edges", 32'(left_cnt), 32'd8);
    tick();
    chk("single_rx_pulse", 32'(rx_valid), 32'd0);
    chk("single_no_underrun", 32'(err_underrun), 32'd0);

    // Back-to-back: 11 then 22, receive 5A then C3
    put_tx(8'h11);
    pload_q.push_back(8'h11);
    pload_q.push_back(8'h22);
    rx_q.push_back(8'h5A);
    rx_q.push_back(8'hC3);
    left_cnt = 0;
    cs_n = 1'b0;
    tick();
    watch_busy = 1'b1;
    tick();
    put_tx(8'h22);
    send_bits(8'h5A, 8);
    tick();
    tick();
    send_bits(8'hC3, 8);
    watch_busy = 1'b0;
    cs_n = 1'b1;
    tick();
    chk("b2b_busy_held", 32'(busy_dropped), 32'd0);
    chk("b2b_rx_data", 32'(rx_data), 32'hC3);
    chk("b2b_left_edges", 32'(left_cnt), 32'd16);
    chk("b2b_tx_ready", 32'(tx_ready), 32'd1);
    tick();

    // Abort after 5 pulses
    put_tx(8'h77);
    pload_q.push_back(8'h77);
    abort_cnt = 0;
    start_frame();
    send_bits(8'hF0, 5);
    cs_n = 1'b1;
    tick();
    chk("abort_pulse", 32'(abort), 32'd1);
    chk("abort_idle", 32'(busy), 32'd0);
    chk("abort_bit_count", 32'(bit_count), 32'd5);
    tick();
    chk("abort_one_cycle", 32'(abort), 32'd0);
    chk("abort_rx_unchanged", 32'(rx_data), 32'hC3);
    chk("abort_count", 32'(abort_cnt), 32'd1);
    chk("abort_buf_not_restored", 32'(tx_ready), 32'd1);

    // Underrun, then overrun injected in DONE
    pload_q.push_back(8'h00);
    rx_q.push_back(8'h81);
    start_frame();
    chk("underrun_set", 32'(err_underrun), 32'd1);
    chk("overrun_clear", 32'(err_overrun), 32'd0);
    send_bits(8'h81, 8);
    mosi = 1'b1;
    sclk_posedge = 1'b1;
    cs_n = 1'b1;
    tick();
    sclk_posedge = 1'b0;
    chk("overrun_set", 32'(err_overrun), 32'd1);
    chk("overrun_no_shift", 32'(sh_q), 32'h81);
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_clr_flags", 32'({err_overrun, err_underrun}), 32'd0);

    // Reset mid-shift after 3 bits
    pload_q.push_back(8'h00);
    start_frame();
    put_tx(8'h9C);
    send_bits(8'hAA, 3);
    chk("pre_rst_bit_count", 32'(bit_count), 32'd3);
    chk("pre_rst_underrun", 32'(err_underrun), 32'd1);
    reset = 1'b1;
    cs_n = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_mode", 32'({shreg_mode, shreg_edge}), 32'd0);
    chk("midrst_tx_ready", 32'(tx_ready), 32'd1);
    chk("midrst_rx_data", 32'(rx_data), 32'd0);
    chk("midrst_flags", 32'({err_overrun, err_underrun}), 32'd0);
    chk("midrst_bit_count", 32'(bit_count), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // Fresh frame after reset
    put_tx(8'hE7);
    pload_q.push_back(8'hE7);
    rx_q.push_back(8'h24);
    start_frame();
    send_bits(8'h24, 8);
    cs_n = 1'b1;
    tick();
    chk("fresh_rx_valid", 32'(rx_valid), 32'd1);
    chk("fresh_rx_data", 32'(rx_data), 32'h24);
    tick();

    // cs_n rises with the 8th pulse: completion, not abort
    put_tx(8'h42);
    pload_q.push_back(8'h42);
    rx_q.push_back(8'h99);
    abort_cnt = 0;
    start_frame();
    send_bits(8'h99, 7);
    repeat (3) tick();
    mosi = 1'b1;
    cs_n = 1'b1;
    sclk_posedge = 1'b1;
    tick();
    sclk_posedge = 1'b0;
    chk("edge_case_no_abort", 32'(abort), 32'd0);
    chk("edge_case_busy_done", 32'(busy), 32'd1);
    tick();
    chk("edge_case_rx_valid", 32'(rx_valid), 32'd1);
    chk("edge_case_rx_data", 32'(rx_data), 32'h99);
    chk("edge_case_idle", 32'(busy), 32'd0);
    tick();
    chk("edge_case_abort_count", 32'(abort_cnt), 32'd0);

    repeat (4) tick();
    chk("pload_queue_drained", 32'(pload_q.size()), 32'd0);
    chk("rx_queue_drained", 32'(rx_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_shift_sequencer.md
Name: spi_shift_sequencer

Overview:
- Sequences one shiftregister8 instance as the serial engine of the SPI multiplier peripheral.
- Per chip-select frame it does three things:
  - parallel-loads the transmit byte;
  - shifts MSB-first, one bit per SCLK sampling edge;
  - hands the received byte to the multiplier core.
- It owns the shift register's mode and edge-enable inputs, a one-entry transmit buffer, frame bit counting, abort handling and error flags.

Parameters:
WIDTH, 8, shift register / frame width in bits
FILL, 8'h00, byte loaded when the transmit buffer is empty at frame/byte start

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
cs_n  input  1  chip select, active low, already synchronized to clk
sclk_posedge  input  1  one-clk pulse per SCLK sampling edge, already synchronized
tx_data  input  WIDTH  byte to transmit next
tx_valid  input  1  tx_data valid; accepted when tx_valid & tx_ready
tx_ready  output  1  transmit buffer empty
shreg_parallel_out  input  WIDTH  shift register parallelOut
shreg_mode  output  2  to shift register mode
shreg_edge  output  1  to shift register serialClkposedge (update enable)
shreg_parallel_in  output  WIDTH  to shift register parallelIn
rx_data  output  WIDTH  last complete received byte
rx_valid  output  1  one-clk pulse, rx_data updated
busy  output  1  state != IDLE
bit_count  output  log2(WIDTH)+1  bits shifted in current byte
abort  output  1  one-clk pulse, frame ended mid-byte
err_overrun  output  1  sticky: sclk_posedge arrived in LOAD/DONE
err_underrun  output  1  sticky: FILL loaded because buffer empty
err_clr  input  1  clears both sticky flags

Behaviour:
- Reset (async): state IDLE; tx buffer empty (tx_ready=1); rx_data=0; rx_valid=0; abort=0; bit_count=0; both error flags 0; shreg_mode=HOLD; shreg_edge=0.
- Mode encodings: HOLD=2'b00, RIGHT=2'b01, LEFT=2'b10, PLOAD=2'b11. Only HOLD, LEFT and PLOAD are driven.
- shreg_mode and shreg_edge are combinational from the registered state and sclk_posedge. All other outputs are registered.
- Transmit buffer:
  - Captures tx_data when tx_valid & tx_ready; tx_ready falls the next cycle.
  - Emptied in the LOAD cycle that consumes it.
  - Capture and consume in the same cycle: the consume wins first; the new byte is stored and the buffer stays full.
- IDLE:
  - Outputs: mode HOLD, edge 0.
  - cs_n=0 → LOAD on the next clk.
- LOAD (exactly 1 cycle):
  - Outputs: mode PLOAD, edge 1.
  - shreg_parallel_in = buffer if full, else FILL (sets err_underrun).
  - bit_count <= 0.
  - → SHIFT.
- SHIFT:
  - Each sclk_posedge: mode LEFT, edge 1 (same cycle), bit_count+1. Otherwise mode HOLD, edge 0.
  - When the WIDTH-th shift occurs → DONE.
- DONE (exactly 1 cycle):
  - Outputs: mode HOLD, edge 0.
  - rx_data <= shreg_parallel_out; rx_valid=1 on the following cycle.
  - cs_n=0 → LOAD (back-to-back bytes, no gap); cs_n=1 → IDLE.
- cs_n=1 in LOAD or SHIFT:
  - → IDLE on the next clk.
  - abort pulse; no rx_valid; rx_data unchanged.
  - Transmit buffer unaffected; a byte consumed in LOAD is not restored.
  - cs_n=1 in the same cycle as the WIDTH-th sclk_posedge counts as completion, not abort (→ DONE).
- sclk_posedge during LOAD or DONE: dropped (no shift), err_overrun set. The system clock must run ≥4× SCLK.
- err_clr and a set event in the same cycle: set wins.
- Latency: cs_n fall to PLOAD is 1 clk; last sclk_posedge to rx_valid is 2 clk.

Decomposition:
- Shared include/package:
  - mode constants HOLD/RIGHT/LEFT/PLOAD (the existing shift-mode definitions, reused);
  - state encodings IDLE=0, LOAD=1, SHIFT=2, DONE=3.
- Natural sub-module: spi_tx_buffer (one-entry valid/ready holding register with consume port).
- FSM, counter and flags stay in the top module.

Test Plan:
- Single frame: tx 8'hA5 buffered, cs_n low, 8 sclk pulses with MOSI pattern 8'h3C → PLOAD of A5 one clk after cs fall, exactly 8 LEFT-mode edge pulses, rx_data=8'h3C with a 1-cycle rx_valid two clk after the 8th pulse, back to IDLE after cs_n rises.
- Back-to-back: buffer 8'h11 then 8'h22 during byte 1, cs held low for 16 pulses → two PLOADs (11, 22), two rx_valid pulses, busy never drops.
- Abort: cs_n rises after 5 pulses → abort pulse, no rx_valid, bit_count stops at 5, IDLE next clk.
- Underrun/overrun: cs low with empty buffer → PLOAD of 8'h00, err_underrun=1. A sclk_posedge injected in a DONE cycle → no shift, err_overrun=1. err_clr clears both flags.
- Reset mid-SHIFT after 3 bits → immediately IDLE, mode HOLD, tx_ready=1, rx_data=0, flags 0. A fresh frame afterwards completes normally.
- Boundary: cs_n rises in the same cycle as the 8th pulse → treated as completion: rx_valid fires, abort does not.
